// File: rtl/avmm_timed_memory.sv
// Line-addressed Avalon-MM memory endpoint. Byte-enabled writes land on the
// acceptance edge; reads snapshot the line at acceptance and are returned
// strictly in order once their due time is reached on the internal cycle clock.
module avmm_timed_memory #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 46,
  parameter int DEPTH           = 2048,
  parameter int READ_LATENCY    = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TS_WIDTH        = 64,
  parameter int TS_MODE         = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               avs_read,
  input  logic                               avs_write,
  input  logic [ADDR_WIDTH-1:0]              avs_address,
  input  logic [DATA_WIDTH/8-1:0]            avs_byteenable,
  input  logic [DATA_WIDTH-1:0]              avs_writedata,
  input  logic [TS_WIDTH-1:0]                avs_timestamp,
  output logic                               avs_waitrequest,
  output logic                               avs_readdatavalid,
  output logic [DATA_WIDTH-1:0]              avs_readdata,
  output logic [TS_WIDTH-1:0]                rsp_timestamp,
  output logic [TS_WIDTH-1:0]                now_ts,
  output logic [31:0]                        rd_count,
  output logic [31:0]                        wr_count,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  // One queued read: snapshot data, echoed timestamp, release time.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TS_WIDTH-1:0]   ts;
    logic [TS_WIDTH-1:0]   due;
  } rd_ent_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  rd_ent_t               q_mem [MAX_OUTSTANDING];

  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TS_WIDTH-1:0]   now_q;
  logic [31:0]           rdcnt_q, wrcnt_q;
  logic                  rdv_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [TS_WIDTH-1:0]   rts_q;

  logic [IW-1:0]         idx;
  logic                  accept, push, do_wr, pop;
  logic [DATA_WIDTH-1:0] line_cur, line_new, rd_line;
  logic [TS_WIDTH-1:0]   due, head_slack;
  rd_ent_t               head;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same line.
  assign idx            = avs_address[IW-1:0];
  assign unused_addr_hi = ^avs_address[ADDR_WIDTH-1:IW];

  // Stall purely on registered occupancy, so a same-cycle pop never lifts it.
  assign avs_waitrequest = (cnt_q == CW'(MAX_OUTSTANDING));
  assign accept = (avs_read | avs_write) & ~avs_waitrequest;
  assign do_wr  = accept & avs_write;
  assign push   = accept & avs_read;

  // Wrap-safe release test: head is due once (now - due) is non-negative.
  assign head       = q_mem[rptr_q];
  assign head_slack = now_q - head.due;
  assign pop        = (cnt_q != '0) & ~head_slack[TS_WIDTH-1];

  assign due = ((TS_MODE == 0) ? now_q : avs_timestamp) + TS_WIDTH'(READ_LATENCY);

  // Merge write lanes into the addressed line; a combined read sees the merge.
  always_comb begin
    line_cur = mem[idx];
    line_new = line_cur;
    for (int b = 0; b < NB; b++) begin
      if (avs_byteenable[b]) line_new[8*b +: 8] = avs_writedata[8*b +: 8];
    end
    rd_line = avs_write ? line_new : line_cur;
  end

  // Queue pointer / occupancy next state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage arrays: memory survives reset, queue slots are qualified by count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[idx] <= line_new;
    if (push)  q_mem[wptr_q] <= '{data: rd_line, ts: avs_timestamp, due: due};
  end

  // Control state, counters and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      now_q   <= '0;
      rdcnt_q <= '0;
      wrcnt_q <= '0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      rts_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      now_q  <= now_q + TS_WIDTH'(1);
      if (push)  rdcnt_q <= rdcnt_q + 32'd1;
      if (do_wr) wrcnt_q <= wrcnt_q + 32'd1;
      rdv_q <= pop;
      if (pop) begin
        rdata_q <= head.data;
        rts_q   <= head.ts;
      end
    end
  end

  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdata_q;
  assign rsp_timestamp     = rts_q;
  assign now_ts            = now_q;
  assign rd_count          = rdcnt_q;
  assign wr_count          = wrcnt_q;
  assign outstanding       = cnt_q;

endmodule
